// File: rtl/mem_bank_scheduler.sv
// Single-port SRAM bank scheduler: round-robin sharing of one 1-cycle-latency
// bank between NumReq OBI-style requesters, plus a zero-init sweep of the bank
// after reset or on demand.
module mem_bank_scheduler #(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned AddrWidth      = 48,
  parameter int unsigned DataWidth      = 512,
  parameter int unsigned SramAddrWidth  = 10,
  parameter int unsigned SramAddrOffset = 6,
  parameter bit          InitOnReset    = 1'b1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 init_start_i,
  output logic                                 init_busy_o,
  output logic                                 init_done_o,
  input  logic [NumReq-1:0]                    req_i,
  output logic [NumReq-1:0]                    gnt_o,
  input  logic [NumReq-1:0]                    we_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]     addr_i,
  input  logic [NumReq-1:0][DataWidth-1:0]     wdata_i,
  input  logic [NumReq-1:0][DataWidth/8-1:0]   be_i,
  output logic [NumReq-1:0]                    rvalid_o,
  output logic [DataWidth-1:0]                 rdata_o,
  output logic                                 mem_req_o,
  output logic                                 mem_we_o,
  output logic [SramAddrWidth-1:0]             mem_addr_o,
  output logic [DataWidth-1:0]                 mem_wdata_o,
  output logic [DataWidth/8-1:0]               mem_be_o,
  input  logic [DataWidth-1:0]                 mem_rdata_i
);

  localparam int unsigned BeWidth  = DataWidth / 8;
  localparam int unsigned PtrWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                     state_q;
  logic [SramAddrWidth-1:0]   cnt_q;
  logic [PtrWidth-1:0]        ptr_q;
  logic [PtrWidth-1:0]        winner;
  logic [PtrWidth-1:0]        ptr_nxt;
  logic                       any_req;
  logic                       grant_en;
  logic                       granted;
  logic [NumReq-1:0]          gnt;
  logic [NumReq-1:0]          rsp_vld_q;
  logic                       done_q;
  logic                       addr_unused;

  // Only the word-address slice of each byte address reaches the bank.
  assign addr_unused = ^addr_i;

  // Rotating-priority search: first requester at or after ptr_q wins.
  always_comb begin
    int idx;
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = 0; k < int'(NumReq); k++) begin
      idx = (int'(ptr_q) + k) % int'(NumReq);
      if (!any_req && req_i[idx]) begin
        any_req = 1'b1;
        winner  = idx[PtrWidth-1:0];
      end
    end
  end

  // Grants only exist in RUN, outside reset, and not while a sweep is being requested.
  assign grant_en = !rst_i && (state_q == ST_RUN) && !init_start_i;

  for (genvar i = 0; i < int'(NumReq); i++) begin : g_gnt
    assign gnt[i] = grant_en && any_req && (winner == PtrWidth'(i));
  end

  assign granted = |gnt;
  assign ptr_nxt = (winner == PtrWidth'(NumReq - 1)) ? '0 : winner + 1'b1;

  // Bank port mux: sweep writes zeros, otherwise the winner's payload, else idle zeros.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (state_q == ST_INIT) begin
      mem_we_o    = 1'b1;
      mem_addr_o  = cnt_q;
      mem_be_o    = {BeWidth{1'b1}};
    end else if (granted) begin
      mem_we_o    = we_i[winner];
      mem_addr_o  = addr_i[winner][SramAddrOffset +: SramAddrWidth];
      mem_wdata_o = wdata_i[winner];
      mem_be_o    = be_i[winner];
    end
  end

  assign mem_req_o = !rst_i && ((state_q == ST_INIT) || granted);

  // Control FSM, sweep counter, RR pointer and one-cycle response pipeline.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= InitOnReset ? ST_INIT : ST_RUN;
      cnt_q     <= '0;
      ptr_q     <= '0;
      rsp_vld_q <= '0;
      done_q    <= 1'b0;
    end else begin
      rsp_vld_q <= gnt;
      done_q    <= 1'b0;
      case (state_q)
        ST_INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (&cnt_q) begin
            cnt_q   <= '0;
            state_q <= ST_RUN;
            done_q  <= 1'b1;
          end
        end
        default: begin
          if (init_start_i) begin
            cnt_q   <= '0;
            state_q <= ST_INIT;
          end else if (granted) begin
            ptr_q <= ptr_nxt;
          end
        end
      endcase
    end
  end

  assign gnt_o       = gnt;
  assign rvalid_o    = rsp_vld_q;
  assign rdata_o     = mem_rdata_i;
  assign init_busy_o = (state_q == ST_INIT);
  assign init_done_o = done_q;

endmodule

// File: tb/tb_mem_bank_scheduler.sv
// Randomised bench for mem_bank_scheduler with a transaction-level reference
// model (sweep progress, RR pointer, owed response, expected memory image).
module tb_mem_bank_scheduler;
  localparam int NR  = 2;
  localparam int AW  = 16;
  localparam int DW  = 64;
  localparam int SAW = 4;
  localparam int SAO = 6;
  localparam int NW  = 16;
  localparam int BW  = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst_i, init_start_i, init_busy_o, init_done_o;
  logic [NR-1:0]             req_i, gnt_o, we_i, rvalid_o;
  logic [NR-1:0][AW-1:0]     addr_i;
  logic [NR-1:0][DW-1:0]     wdata_i;
  logic [NR-1:0][BW-1:0]     be_i;
  logic [DW-1:0]             rdata_o, mem_wdata_o, mem_rdata_i;
  logic                      mem_req_o, mem_we_o;
  logic [SAW-1:0]            mem_addr_o;
  logic [BW-1:0]             mem_be_o;

  mem_bank_scheduler #(
    .NumReq(NR), .AddrWidth(AW), .DataWidth(DW), .SramAddrWidth(SAW),
    .SramAddrOffset(SAO), .InitOnReset(1'b1)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .init_start_i(init_start_i),
    .init_busy_o(init_busy_o), .init_done_o(init_done_o),
    .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .be_i(be_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
  );

  // Bank macro: byte-masked write, 1-cycle registered read.
  logic [DW-1:0] bank [NW];
  always @(posedge clk) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < BW; b++)
          if (mem_be_o[b]) bank[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else begin
        mem_rdata_i <= bank[mem_addr_o];
      end
    end
  end

  typedef struct {
    bit            act;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
  } preq_t;

  preq_t         pq [NR];
  logic [DW-1:0] ref_mem [NW];
  int            m_sweep;      // next sweep word, -1 when not sweeping
  int            m_ptr;
  int            m_pend;       // port owed a response, -1 if none
  bit            m_pend_rd;
  logic [DW-1:0] m_pend_data;
  bit            m_done;
  bit            m_known;
  int            checks;
  int            failures;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic arm(input int p, input bit we, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic [BW-1:0] be);
    pq[p].act = 1'b1; pq[p].we = we; pq[p].addr = a; pq[p].wdata = d; pq[p].be = be;
  endtask

  task automatic rand_arm(input int p);
    arm(p, 1'($urandom_range(0, 1)), AW'($urandom), {$urandom, $urandom}, BW'($urandom));
  endtask

  // One clock cycle: drive, check against the model, then advance the model.
  task automatic step(input bit r, input bit is);
    int w;
    int a;
    @(negedge clk);
    rst_i = r;
    init_start_i = is;
    for (int p = 0; p < NR; p++) begin
      req_i[p] = pq[p].act; we_i[p] = pq[p].we; addr_i[p] = pq[p].addr;
      wdata_i[p] = pq[p].wdata; be_i[p] = pq[p].be;
    end
    #1;
    w = -1;
    if (!r && m_known && m_sweep < 0 && !is)
      for (int k = 0; k < NR; k++)
        if (w < 0 && pq[(m_ptr + k) % NR].act) w = (m_ptr + k) % NR;
    if (m_known) begin
      chk("rvalid", 64'(rvalid_o), (m_pend >= 0) ? 64'(1 << m_pend) : 64'd0);
      if (m_pend >= 0 && m_pend_rd) chk("rdata", rdata_o, m_pend_data);
      chk("init_done", 64'(init_done_o), 64'(m_done));
      chk("init_busy", 64'(init_busy_o), 64'(m_sweep >= 0));
    end
    if (r) begin
      chk("rst_gnt", 64'(gnt_o), 64'd0);
      chk("rst_mem_req", 64'(mem_req_o), 64'd0);
    end else if (m_sweep >= 0) begin
      chk("sw_gnt", 64'(gnt_o), 64'd0);
      chk("sw_req", 64'(mem_req_o), 64'd1);
      chk("sw_we", 64'(mem_we_o), 64'd1);
      chk("sw_addr", 64'(mem_addr_o), 64'(m_sweep));
      chk("sw_wdata", mem_wdata_o, 64'd0);
      chk("sw_be", 64'(mem_be_o), 64'hff);
    end else begin
      chk("gnt", 64'(gnt_o), (w >= 0) ? 64'(1 << w) : 64'd0);
      chk("mem_req", 64'(mem_req_o), 64'(w >= 0));
      if (w >= 0) begin
        chk("mem_we", 64'(mem_we_o), 64'(pq[w].we));
        chk("mem_addr", 64'(mem_addr_o), 64'(pq[w].addr[SAO +: SAW]));
        chk("mem_wdata", mem_wdata_o, pq[w].wdata);
        chk("mem_be", 64'(mem_be_o), 64'(pq[w].be));
      end else begin
        chk("idle_addr", 64'(mem_addr_o), 64'd0);
        chk("idle_wdata", mem_wdata_o, 64'd0);
        chk("idle_be", 64'(mem_be_o), 64'd0);
      end
    end
    @(posedge clk);
    if (r) begin
      m_known = 1'b1; m_sweep = 0; m_ptr = 0; m_pend = -1; m_done = 1'b0;
    end else begin
      m_done = (m_sweep == NW - 1);
      m_pend = w;
      if (m_sweep >= 0) begin
        ref_mem[m_sweep] = '0;
        m_sweep = (m_sweep == NW - 1) ? -1 : m_sweep + 1;
      end else if (is) begin
        m_sweep = 0;
      end else if (w >= 0) begin
        m_ptr = (w + 1) % NR;
        a = int'(pq[w].addr[SAO +: SAW]);
        m_pend_rd = !pq[w].we;
        if (pq[w].we) begin
          for (int b = 0; b < BW; b++)
            if (pq[w].be[b]) ref_mem[a][8*b +: 8] = pq[w].wdata[8*b +: 8];
        end else begin
          m_pend_data = ref_mem[a];
        end
        pq[w].act = 1'b0;
      end
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 40; n++) begin
      if (!pq[0].act && !pq[1].act) break;
      step(1'b0, 1'b0);
    end
    chk("drain_done", 64'(pq[0].act || pq[1].act), 64'd0);
  endtask

  initial begin
    checks = 0; failures = 0;
    m_known = 1'b0; m_sweep = -1; m_ptr = 0; m_pend = -1; m_pend_rd = 1'b0;
    m_pend_data = '0; m_done = 1'b0;
    for (int i = 0; i < NW; i++) begin
      bank[i] = {$urandom, $urandom};
      ref_mem[i] = bank[i];
    end
    for (int p = 0; p < NR; p++) pq[p] = '{1'b0, 1'b0, '0, '0, '0};
    rst_i = 1'b1; init_start_i = 1'b0; req_i = '0; we_i = '0;
    addr_i = '0; wdata_i = '0; be_i = '0;

    // Reset sweep: 16 zero writes, done pulse afterwards; requests ignored meanwhile.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    rand_arm(1);
    repeat (18) step(1'b0, 1'b0);
    drain();

    // Single read of byte address 0x80 (word 2).
    arm(0, 1'b0, 16'h0080, '0, '0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Round-robin with both ports requesting continuously.
    for (int c = 0; c < 6; c++) begin
      for (int p = 0; p < NR; p++)
        if (!pq[p].act) arm(p, 1'b0, AW'($urandom), '0, '0);
      step(1'b0, 1'b0);
    end
    drain();
    step(1'b0, 1'b0);

    // Write-then-read on port 1: partial write to word 3.
    arm(1, 1'b1, 16'h00C0, {8{8'hA5}}, 8'h0F);
    step(1'b0, 1'b0);
    arm(1, 1'b0, 16'h00C0, '0, '0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("wr_rd_image", ref_mem[3], 64'h00000000A5A5A5A5);

    // Init request right after a granted read, port 0 waiting through the sweep.
    arm(0, 1'b0, 16'h0040, '0, '0);
    step(1'b0, 1'b0);
    arm(0, 1'b0, 16'h0140, '0, '0);
    step(1'b0, 1'b1);
    repeat (17) step(1'b0, 1'b0);
    chk("post_init_grant", 64'(pq[0].act), 64'd0);
    step(1'b0, 1'b0);

    // Reset asserted at sweep word 7; sweep restarts from word 0.
    step(1'b0, 1'b1);
    repeat (7) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    repeat (18) step(1'b0, 1'b0);

    // Random traffic with occasional sweeps and resets.
    for (int c = 0; c < 800; c++) begin
      for (int p = 0; p < NR; p++)
        if (!pq[p].act && ($urandom % 3 == 0)) rand_arm(p);
      step(1'($urandom % 250 == 0), 1'($urandom % 60 == 0));
    end
    drain();
    step(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
